skewed_weight_fifo: RTL and testbench
=====================================

Name: skewed_weight_fifo

Overview:
Parametrised successor to the 3-column weight FIFO. It provides N_COLS independent weight queues of configurable depth and width, and a per-column wavefront skew of c pops for column c. It feeds the weight-load port of an N_COLS×N_COLS systolic MMU. Compared with the fixed 3-column version it adds full/empty/count status, zero-bubble insertion when a column is empty, sticky overflow flags, and an idle indication once the skew pipeline has fully drained.

Parameters:
N_COLS, 3, number of columns / queues (≥1)
DATA_W, 8, weight width in bits
DEPTH, 4, entries per queue (power of two, ≥2)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, localparam)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  synchronous clear of pointers, counts, skew stages and error flags
push  input  N_COLS  per-column write enable
data_in  input  N_COLS*DATA_W  column c occupies bits [c*DATA_W +: DATA_W]
pop  input  1  common advance for all columns (MMU weight-shift strobe)
col_out  output  N_COLS*DATA_W  skewed weights, same packing as data_in
full  output  N_COLS  count_c == DEPTH
empty  output  N_COLS  count_c == 0
count  output  N_COLS*CNT_W  per-column occupancy
overflow  output  N_COLS  sticky: push attempted while full
idle  output  1  all queues empty and no valid data in any skew stage

Behaviour:
- Reset (rst_n low, async): all pointers, counts, skew stages, stage-valid bits and overflow clear. col_out = 0, empty = all ones, full = 0, count = 0, idle = 1.
- head_c = empty_c ? 0 : queue_c[rd_ptr_c]. An empty queue always presents a zero bubble and never exposes stale RAM.
- Column 0: col_out[0] = head_0, combinational, zero skew.
- Column c≥1: c-stage shift register S_c[0..c-1], each stage with a valid bit.
  - On pop: S_c[0] <= head_c, valid <= !empty_c; S_c[k] <= S_c[k-1] for k≥1.
  - col_out[c] = S_c[c-1].
  - Without pop, stages hold their values.
- Push: when push[c] && !full_c, write data_in[c] at wr_ptr_c and increment wr_ptr_c.
- Push while full: data is dropped, wr_ptr and count are unchanged, and overflow[c] is set.
- Pop with !empty_c: increment rd_ptr_c.
- Pop with empty_c: rd_ptr_c is unchanged, a zero bubble enters the skew chain, and no error is flagged. Flush pops past the end of data are legal.
- Pointers wrap modulo DEPTH.
- count_c changes by +1 on an accepted push, −1 on an effective pop, and is unchanged when both occur.
- Simultaneous push and pop while full: the pop frees a slot, the push is accepted, count stays DEPTH, and overflow is not set.
- Simultaneous push and pop while empty: the pop yields a bubble, the push is accepted, and count becomes 1.
- load_start has priority over everything in its cycle:
  - pointers, counts, skew stages, valid bits and overflow are cleared;
  - a pop in the same cycle is ignored;
  - a push[c] in the same cycle is accepted into slot 0, giving wr_ptr = 1 and count = 1.
- idle = &empty && no stage-valid bit set. It is registered-state-derived and combinational (no extra latency).
- Latency: a word at the head of column c appears on col_out[c] after c pops. With DEPTH=4, N_COLS=3 and a full load, DEPTH+N_COLS−1 = 6 pops drain every column.

Test Plan:
1. Reset, then push 4 words per column (col0 = 0x10..0x13, col1 = 0x20..0x23, col2 = 0x30..0x33), then 6 consecutive pops.
   - Required col_out after each pop: col0 0x11,0x12,0x13,0,0,0; col1 0x20..0x23 then 0; col2 0,0x30..0x33,0.
   - idle rises after pop 6.
2. Fill col1 to DEPTH, then one more push of 0xFF → overflow[1] = 1, count[1] = 4, 0xFF never appears on the output. A subsequent load_start clears overflow.
3. Col0 full, same-cycle push 0xAA and pop → count stays 4, overflow = 0, and 0xAA emerges as the last word.
4. Pop 10× with all queues empty → col_out stays all zero, count stays 0, pointers do not move, idle stays 1.
5. Mid-drain (after 2 pops of scenario 1), load_start with push[0] = 1 and data 0x55 → all stages zero, count[0] = 1, col_out[0] = 0x55, other counts 0.
6. Assert rst_n low asynchronously between edges mid-operation → outputs zero immediately. Rerun with N_COLS=4, DEPTH=8 and scenario 1 scaled: col3 skew is 3 pops and a full drain takes 11 pops.

Source files
------------

// File: rtl/skewed_weight_fifo.sv
// skewed_weight_fifo: N_COLS independent weight queues, column c skewed
// by c pops, feeding the weight-load port of a systolic MMU.
module skewed_weight_fifo #(
  parameter int N_COLS = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic [N_COLS-1:0]        push,
  input  logic [N_COLS*DATA_W-1:0] data_in,
  input  logic                     pop,
  output logic [N_COLS*DATA_W-1:0] col_out,
  output logic [N_COLS-1:0]        full,
  output logic [N_COLS-1:0]        empty,
  output logic [N_COLS*CNT_W-1:0]  count,
  output logic [N_COLS-1:0]        overflow,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [N_COLS-1:0] busy;

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              is_full;
    logic              is_empty;
    logic              do_push;
    logic              do_pop;
    logic              we;
    logic [PTR_W-1:0]  wa;
    logic [DATA_W-1:0] head;

    assign is_full  = (cnt == CNT_W'(DEPTH));
    assign is_empty = (cnt == '0);
    assign do_pop   = pop && !is_empty;
    // a pop on a full queue frees the slot this push lands in
    assign do_push  = push[c] && (!is_full || pop);
    assign head     = is_empty ? '0 : mem[rd_ptr];

    assign we = load_start ? push[c] : do_push;
    assign wa = load_start ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
      if (we) mem[wa] <= data_in[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else if (load_start) begin
        rd_ptr <= '0;
        wr_ptr <= PTR_W'(push[c]);
        cnt    <= CNT_W'(push[c]);
        ovf    <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push[c] && !do_push) ovf <= 1'b1;
        if (do_push && !do_pop)
          cnt <= cnt + 1'b1;
        else if (!do_push && do_pop)
          cnt <= cnt - 1'b1;
      end
    end

    assign full[c]                   = is_full;
    assign empty[c]                  = is_empty;
    assign overflow[c]               = ovf;
    assign count[c*CNT_W +: CNT_W]   = cnt;

    if (c == 0) begin : g_s0
      assign col_out[DATA_W-1:0] = head;
      assign busy[0]             = 1'b0;
    end else begin : g_sk
      logic [c-1:0] sv;

      for (genvar k = 0; k < c; k++) begin : g_stg
        logic [DATA_W-1:0] d;
        logic              v;
        logic [DATA_W-1:0] sin;
        logic              vin;

        if (k == 0) begin : g_first
          assign sin = head;
          assign vin = !is_empty;
        end else begin : g_next
          assign sin = g_stg[k-1].d;
          assign vin = g_stg[k-1].v;
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            d <= '0;
            v <= 1'b0;
          end else if (load_start) begin
            d <= '0;
            v <= 1'b0;
          end else if (pop) begin
            d <= sin;
            v <= vin;
          end
        end

        assign sv[k] = v;
      end

      assign col_out[c*DATA_W +: DATA_W] = g_stg[c-1].d;
      assign busy[c]                     = |sv;
    end
  end

  assign idle = (&empty) && !(|busy);

endmodule

// File: tb/tb_skewed_weight_fifo.sv
// Bench for skewed_weight_fifo: directed tables, corner sequences and a
// queue-based reference model under random stimulus, two configurations.
module tb_skewed_weight_fifo;

  localparam int W  = 8;
  localparam int NA = 3;
  localparam int DA = 4;
  localparam int CA = $clog2(DA + 1);
  localparam int NB = 4;
  localparam int DB = 8;
  localparam int CB = $clog2(DB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            a_ls = 1'b0;
  logic [NA-1:0]   a_push = '0;
  logic [NA*W-1:0] a_din = '0;
  logic            a_pop = 1'b0;
  logic [NA*W-1:0] a_out;
  logic [NA-1:0]   a_full, a_empty, a_ovf;
  logic [NA*CA-1:0] a_cnt;
  logic            a_idle;

  logic            b_ls = 1'b0;
  logic [NB-1:0]   b_push = '0;
  logic [NB*W-1:0] b_din = '0;
  logic            b_pop = 1'b0;
  logic [NB*W-1:0] b_out;
  logic [NB-1:0]   b_full, b_empty, b_ovf;
  logic [NB*CB-1:0] b_cnt;
  logic            b_idle;

  skewed_weight_fifo #(.N_COLS(NA), .DATA_W(W), .DEPTH(DA)) u_a (
    .clk(clk), .rst_n(rst_n), .load_start(a_ls), .push(a_push),
    .data_in(a_din), .pop(a_pop), .col_out(a_out), .full(a_full),
    .empty(a_empty), .count(a_cnt), .overflow(a_ovf), .idle(a_idle)
  );

  skewed_weight_fifo #(.N_COLS(NB), .DATA_W(W), .DEPTH(DB)) u_b (
    .clk(clk), .rst_n(rst_n), .load_start(b_ls), .push(b_push),
    .data_in(b_din), .pop(b_pop), .col_out(b_out), .full(b_full),
    .empty(b_empty), .count(b_cnt), .overflow(b_ovf), .idle(b_idle)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: plain queues of words plus a history of
  // what each pop delivered (bit W = real word, not a bubble)
  logic [W-1:0] mq [NA][$];
  logic [W:0]   hist [NA][$];
  bit           movf [NA];

  function automatic void m_clear();
    for (int c = 0; c < NA; c++) begin
      mq[c].delete();
      hist[c].delete();
      movf[c] = 1'b0;
    end
  endfunction

  function automatic void m_step(input logic ls, input logic [NA-1:0] ps,
                                 input logic [NA*W-1:0] d, input logic pp);
    if (ls) begin
      m_clear();
      for (int c = 0; c < NA; c++)
        if (ps[c]) mq[c].push_back(d[c*W +: W]);
      return;
    end
    for (int c = 0; c < NA; c++) begin
      int sz;
      logic [W-1:0] hd;
      sz = mq[c].size();
      hd = (sz != 0) ? mq[c][0] : '0;
      if (pp) begin
        hist[c].push_front({sz != 0, hd});
        if (hist[c].size() > NA) void'(hist[c].pop_back());
        if (sz != 0) void'(mq[c].pop_front());
      end
      if (ps[c]) begin
        if (sz < DA || pp) mq[c].push_back(d[c*W +: W]);
        else movf[c] = 1'b1;
      end
    end
  endfunction

  task automatic chk_model(input string tag);
    logic [NA*W-1:0]  eo;
    logic [NA*CA-1:0] ec;
    logic [NA-1:0]    ef, ee, ev;
    logic             ei;
    eo = '0; ec = '0; ef = '0; ee = '0; ev = '0; ei = 1'b1;
    for (int c = 0; c < NA; c++) begin
      int sz;
      sz = mq[c].size();
      ec[c*CA +: CA] = CA'(sz);
      ef[c] = (sz == DA);
      ee[c] = (sz == 0);
      ev[c] = movf[c];
      if (sz != 0) ei = 1'b0;
      if (c == 0) begin
        eo[W-1:0] = (sz != 0) ? mq[0][0] : '0;
      end else begin
        if (hist[c].size() >= c) eo[c*W +: W] = hist[c][c-1][W-1:0];
        for (int k = 0; k < c && k < hist[c].size(); k++)
          if (hist[c][k][W]) ei = 1'b0;
      end
    end
    chk({tag, " col_out"}, 64'(a_out), 64'(eo));
    chk({tag, " count"}, 64'(a_cnt), 64'(ec));
    chk({tag, " full"}, 64'(a_full), 64'(ef));
    chk({tag, " empty"}, 64'(a_empty), 64'(ee));
    chk({tag, " overflow"}, 64'(a_ovf), 64'(ev));
    chk({tag, " idle"}, 64'(a_idle), 64'(ei));
  endtask

  task automatic a_step(input logic ls, input logic [NA-1:0] ps,
                        input logic [NA*W-1:0] d, input logic pp);
    a_ls = ls; a_push = ps; a_din = d; a_pop = pp;
    @(posedge clk);
    m_step(ls, ps, d, pp);
    #1;
    a_ls = 1'b0; a_push = '0; a_din = '0; a_pop = 1'b0;
  endtask

  task automatic b_step(input logic ls, input logic [NB-1:0] ps,
                        input logic [NB*W-1:0] d, input logic pp);
    b_ls = ls; b_push = ps; b_din = d; b_pop = pp;
    @(posedge clk);
    #1;
    b_ls = 1'b0; b_push = '0; b_din = '0; b_pop = 1'b0;
  endtask

  function automatic logic [NA*W-1:0] put(input int c, input logic [W-1:0] v);
    logic [NA*W-1:0] r;
    r = '0;
    r[c*W +: W] = v;
    return r;
  endfunction

  function automatic logic [NA*W-1:0] row_a(input int i);
    return {W'(8'h30 + i), W'(8'h20 + i), W'(8'h10 + i)};
  endfunction

  typedef struct {
    logic [NA*W-1:0] out;
    logic            idle;
  } vec_t;

  vec_t tv [6];

  initial begin
    tv[0] = '{24'h002011, 1'b0};
    tv[1] = '{24'h302112, 1'b0};
    tv[2] = '{24'h312213, 1'b0};
    tv[3] = '{24'h322300, 1'b0};
    tv[4] = '{24'h330000, 1'b0};
    tv[5] = '{24'h000000, 1'b1};

    m_clear();
    #3;
    chk("rst col_out", 64'(a_out), 64'd0);
    chk("rst empty", 64'(a_empty), 64'h7);
    chk("rst full", 64'(a_full), 64'd0);
    chk("rst count", 64'(a_cnt), 64'd0);
    chk("rst overflow", 64'(a_ovf), 64'd0);
    chk("rst idle", 64'(a_idle), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // full load then table-driven drain
    for (int i = 0; i < DA; i++) a_step(1'b0, 3'b111, row_a(i), 1'b0);
    chk("load col_out", 64'(a_out), 64'h000010);
    chk("load full", 64'(a_full), 64'h7);
    chk("load idle", 64'(a_idle), 64'd0);
    for (int i = 0; i < 6; i++) begin
      a_step(1'b0, '0, '0, 1'b1);
      chk($sformatf("drain%0d col_out", i + 1), 64'(a_out), 64'(tv[i].out));
      chk($sformatf("drain%0d idle", i + 1), 64'(a_idle), 64'(tv[i].idle));
      chk_model("drain");
    end

    // overflow on col1
    for (int i = 0; i < DA; i++) a_step(1'b0, 3'b010, put(1, W'(8'h40 + i)), 1'b0);
    a_step(1'b0, 3'b010, put(1, 8'hFF), 1'b0);
    chk("ovf flag", 64'(a_ovf[1]), 64'd1);
    chk("ovf count", 64'(a_cnt[CA +: CA]), 64'd4);
    chk_model("ovf");
    for (int p = 1; p <= 5; p++) begin
      a_step(1'b0, '0, '0, 1'b1);
      chk($sformatf("ovf drain%0d", p), 64'(a_out[W +: W]),
          (p <= 4) ? 64'(8'h40 + p - 1) : 64'd0);
    end
    a_step(1'b1, '0, '0, 1'b0);
    chk("ovf cleared", 64'(a_ovf), 64'd0);

    // push and pop together on a full col0
    for (int i = 0; i < DA; i++) a_step(1'b0, 3'b001, put(0, W'(8'h60 + i)), 1'b0);
    a_step(1'b0, 3'b001, put(0, 8'hAA), 1'b1);
    chk("pp full count", 64'(a_cnt[CA-1:0]), 64'd4);
    chk("pp full ovf", 64'(a_ovf[0]), 64'd0);
    chk("pp full head", 64'(a_out[W-1:0]), 64'h61);
    for (int p = 0; p < 4; p++) begin
      logic [W-1:0] e;
      e = (p == 0) ? 8'h62 : (p == 1) ? 8'h63 : (p == 2) ? 8'hAA : 8'h00;
      a_step(1'b0, '0, '0, 1'b1);
      chk($sformatf("pp drain%0d", p), 64'(a_out[W-1:0]), 64'(e));
      chk_model("pp");
    end

    // flush pops on empty queues
    for (int p = 0; p < 10; p++) begin
      a_step(1'b0, '0, '0, 1'b1);
      chk("empty pop col_out", 64'(a_out), 64'd0);
      chk("empty pop count", 64'(a_cnt), 64'd0);
      chk("empty pop idle", 64'(a_idle), 64'd1);
    end
    a_step(1'b0, 3'b001, put(0, 8'h77), 1'b0);
    chk("empty pop ptr", 64'(a_out[W-1:0]), 64'h77);
    a_step(1'b1, '0, '0, 1'b0);

    // load_start mid-drain with a push
    for (int i = 0; i < DA; i++) a_step(1'b0, 3'b111, row_a(i), 1'b0);
    a_step(1'b0, '0, '0, 1'b1);
    a_step(1'b0, '0, '0, 1'b1);
    a_step(1'b1, 3'b001, put(0, 8'h55), 1'b1);
    chk("ls col_out", 64'(a_out), 64'h000055);
    chk("ls count", 64'(a_cnt), 64'h001);
    chk_model("ls");

    // async reset between edges
    a_step(1'b0, 3'b111, row_a(7), 1'b1);
    a_step(1'b0, 3'b110, row_a(8), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    m_clear();
    chk("arst col_out", 64'(a_out), 64'd0);
    chk("arst count", 64'(a_cnt), 64'd0);
    chk("arst empty", 64'(a_empty), 64'h7);
    chk("arst idle", 64'(a_idle), 64'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic            ls;
      logic [NA-1:0]   ps;
      logic [NA*W-1:0] d;
      logic            pp;
      ls = ($urandom_range(0, 29) == 0);
      ps = NA'($urandom);
      d  = (NA*W)'($urandom);
      pp = 1'($urandom_range(0, 1));
      a_step(ls, ps, d, pp);
      chk_model("rnd");
    end

    // wider configuration: 4 columns, depth 8, 11-pop drain
    for (int i = 0; i < DB; i++)
      b_step(1'b0, 4'hF, {W'(8'h40 + i), W'(8'h30 + i), W'(8'h20 + i),
                          W'(8'h10 + i)}, 1'b0);
    chk("b load count", 64'(b_cnt), 64'h8888);
    chk("b load full", 64'(b_full), 64'hF);
    for (int p = 1; p <= DB + NB - 1; p++) begin
      logic [NB*W-1:0] e;
      e = '0;
      for (int c = 0; c < NB; c++) begin
        int idx;
        idx = p - c;
        if (idx >= 0 && idx < DB) e[c*W +: W] = W'(16 * (c + 1) + idx);
      end
      b_step(1'b0, '0, '0, 1'b1);
      chk($sformatf("b drain%0d col_out", p), 64'(b_out), 64'(e));
      chk($sformatf("b drain%0d idle", p), 64'(b_idle),
          64'(p == DB + NB - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
